// File: rtl/fetch_pkg.sv
// fetch_pkg: default sizes and occupancy counter type shared by the fetch unit
package fetch_pkg;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int INSTR_WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = $clog2(DEPTH_DEF + 1);
  typedef logic [CNT_W_DEF-1:0] count_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO of pc-tagged instructions with single-cycle flush
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = INSTR_WIDTH_DEF + ADDR_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic do_pop, do_push;
  assign valid_o = count_q != '0;
  assign do_pop = pop_i & valid_o;
  assign do_push = push_i & ~flush_i & (count_q != FULL | do_pop);
  assign data_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = count_q;
  // Storage is left unreset; reads are masked while the queue is empty
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_q + PW'(do_pop);
      wr_q <= wr_q + PW'(do_push);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect flush and decode buffer
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_addr,
  output logic                   o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rsp_data,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr_data,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  input  logic                   i_instr_ready
);
  localparam int CW = cnt_w(DEPTH);
  localparam int FW = INSTR_WIDTH + ADDR_WIDTH;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_count;
  logic [CW:0] level;
  logic req_fire, rsp_ok, push;
  logic [FW-1:0] fifo_out;
  // Requests are throttled so every in-flight response is guaranteed a buffer slot
  assign level = {1'b0, fifo_count} + {1'b0, out_q};
  assign o_mem_req_valid = n_rst & (level < FULL);
  assign o_mem_req_addr = fetch_pc_q;
  assign req_fire = o_mem_req_valid & i_mem_req_ready;
  assign rsp_ok = i_mem_rsp_valid & (out_q != '0);
  assign push = rsp_ok & ~i_redirect & (drop_q == '0);
  assign {o_instr_pc, o_instr_data} = fifo_out;
  // On redirect every still-unanswered request becomes stale and must be dropped
  always_comb begin
    out_d = out_q + CW'(req_fire) - CW'(rsp_ok);
    fetch_pc_d = i_redirect ? i_redirect_addr : fetch_pc_q + ADDR_WIDTH'(req_fire);
    rsp_pc_d = i_redirect ? i_redirect_addr : rsp_pc_q + ADDR_WIDTH'(push);
    drop_d = i_redirect ? out_d : drop_q - CW'(rsp_ok & (drop_q != '0));
  end
  // Fetch/response pointers and in-flight bookkeeping
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      fetch_pc_q <= '0;
      rsp_pc_q <= '0;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  instr_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .flush_i (i_redirect),
    .push_i  (push),
    .data_i  ({rsp_pc_q, i_mem_rsp_data}),
    .pop_i   (i_instr_ready),
    .valid_o (o_instr_valid),
    .data_o  (fifo_out),
    .count_o (fifo_count)
  );
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32, word address width.
REQ-002 The module SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-003 The module SHALL have parameter DEPTH, default 4, instruction buffer entries; power of two, >=2.
REQ-004 The module SHALL have port clk  in  1  clock; all state on rising edge.
REQ-005 The module SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-006 The module SHALL have port i_redirect  in  1  jump taken; flush and restart fetch.
REQ-007 The module SHALL have port i_redirect_addr  in  ADDR_WIDTH  jump target word address.
REQ-008 The module SHALL have port o_mem_req_valid  out  1  fetch request valid.
REQ-009 The module SHALL have port o_mem_req_addr  out  ADDR_WIDTH  fetch word address.
REQ-010 The module SHALL have port i_mem_req_ready  in  1  memory accepts request.
REQ-011 The module SHALL have port i_mem_rsp_valid  in  1  in-order read data valid.
REQ-012 The module SHALL have port i_mem_rsp_data  in  INSTR_WIDTH  read data.
REQ-013 The module SHALL have port o_instr_valid  out  1  instruction available to decode.
REQ-014 The module SHALL have port o_instr_data  out  INSTR_WIDTH  instruction word.
REQ-015 The module SHALL have port o_instr_pc  out  ADDR_WIDTH  address of o_instr_data.
REQ-016 The module SHALL have port i_instr_ready  in  1  decode accepts instruction.

Function
REQ-017 Request handshake SHALL be req_fire = o_mem_req_valid & i_mem_req_ready; output handshake instr_fire = o_instr_valid & i_instr_ready.
REQ-018 o_mem_req_addr SHALL equal internal fetch_pc; fetch_pc SHALL increment by 1 on req_fire, wrapping modulo 2^ADDR_WIDTH.
REQ-019 o_mem_req_valid SHALL be registered-state-only (no combinational path from i_redirect or i_mem_req_ready) and high iff fifo_count + outstanding < DEPTH.
REQ-020 outstanding SHALL count accepted requests with no response yet: +1 on req_fire, -1 on i_mem_rsp_valid, both same cycle = unchanged; never exceeds DEPTH.
REQ-021 A response with drop_count = 0 and no redirect SHALL be pushed into the buffer with tag rsp_pc; rsp_pc then increments by 1 with wrap.
REQ-022 A pushed response SHALL appear on o_instr_valid the following cycle at the earliest (1-cycle latency); o_instr_valid held until instr_fire.
REQ-023 The buffer SHALL be FIFO ordered; simultaneous push and pop SHALL be legal at any occupancy including full; overflow is impossible by REQ-019.
REQ-024 While o_instr_valid=1 and i_instr_ready=0, o_instr_data and o_instr_pc SHALL remain stable.
REQ-025 On i_redirect=1: next cycle fetch_pc and rsp_pc SHALL equal i_redirect_addr; buffer SHALL be empty; o_instr_valid SHALL be 0.
REQ-026 On redirect, drop_count SHALL be set to outstanding + req_fire - i_mem_rsp_valid (all same-cycle values); any response in the redirect cycle SHALL be discarded.
REQ-027 A response arriving with drop_count > 0 SHALL be discarded and decrement drop_count; rsp_pc unchanged.
REQ-028 New requests SHALL be issued while drop_count > 0; stale responses precede them by in-order memory.
REQ-029 instr_fire in a redirect cycle SHALL complete normally for decode; buffer contents otherwise discarded.
REQ-030 A response with outstanding = 0 SHALL be ignored (protocol error).

Reset
REQ-031 n_rst low SHALL immediately clear fetch_pc, rsp_pc, outstanding, drop_count, fifo_count to 0; o_mem_req_valid, o_instr_valid, o_mem_req_addr, o_instr_pc, o_instr_data SHALL read 0.
REQ-032 After n_rst deassertion, first request SHALL be address 0 with o_mem_req_valid=1 on the first clock edge.
REQ-033 Reset mid-operation SHALL abandon in-flight requests; no response is forwarded until a new request completes.

Structure
REQ-034 Package fetch_pkg SHALL hold default parameter constants and the count type (clog2(DEPTH+1) bits).
REQ-035 Buffer SHALL be sub-module instr_fifo: synchronous FIFO, width INSTR_WIDTH+ADDR_WIDTH, with synchronous flush input.

Verification
REQ-036 Reset release, ready always 1, 1-cycle memory, decode ready -> instructions at pc 0,1,2,3... in order, data matching memory.
REQ-037 Decode ready=0 for 10 cycles -> exactly DEPTH (4) requests outstanding+buffered, o_mem_req_valid=0, outputs stable.
REQ-038 Redirect to 0x100 with 3 outstanding, 3-cycle memory latency -> 3 stale responses dropped, first output pc 0x100.
REQ-039 Redirect in same cycle as req_fire and rsp_valid -> drop_count = outstanding, no stale instruction emitted.
REQ-040 fetch_pc at 0xFFFFFFFF -> next request address 0x00000000, o_instr_pc wraps identically.
REQ-041 Assert n_rst mid-stream with 2 outstanding -> all outputs 0 asynchronously, restart at address 0.
